// File: rtl/mem_arb_pkg.sv
// Shared constants and state type for the DDR2 write-port arbiter.
package mem_arb_pkg;

    localparam int unsigned REQ_BYPASS = 0;
    localparam int unsigned REQ_FILLER = 1;
    localparam int unsigned REQ_LINE   = 2;
    localparam int unsigned NREQ       = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Requester id successor, wrapping modulo NREQ.
    function automatic logic [1:0] rr_next(input logic [1:0] id);
        return (id == 2'(NREQ - 1)) ? 2'd0 : id + 2'd1;
    endfunction

endpackage

// File: rtl/mem_wr_arbiter_rr_pick.sv
// Round-robin picker: first valid requester starting at ptr, wrapping modulo 3.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [NREQ-1:0] valid,
    input  logic [1:0]      ptr,
    output logic [1:0]      winner,
    output logic            any
);

    logic [1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = ptr;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!any && valid[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
            idx = rr_next(idx);
        end
    end

endmodule

// File: rtl/mem_wr_arbiter.sv
// Burst-granular round-robin arbiter sharing the DDR2 write-request port
// among CPU bypass (0), frame filler (1) and line engine (2).
module mem_wr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 31,
    parameter int unsigned DATA_W       = 128,
    parameter int unsigned MASK_W       = 16,
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_last,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ*MASK_W-1:0] req_mask,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_data,
    output logic [MASK_W-1:0]      mem_mask,
    output logic [1:0]             mem_src,
    output logic                   busy
);

    localparam int unsigned BCNT_W = $clog2(MAX_BURST + 1);
    localparam int unsigned ICNT_W = $clog2(IDLE_TIMEOUT + 1);

    arb_state_t        state;
    logic [1:0]        owner;
    logic [1:0]        rr_ptr;
    logic [BCNT_W-1:0] beat_cnt;
    logic [ICNT_W-1:0] idle_cnt;

    logic [1:0]        pick_winner;
    logic              pick_any;
    logic              locked;
    logic              own_valid;
    logic              own_last;
    logic              hs;
    logic              rel;

    logic [ADDR_W-1:0] addr_a [NREQ];
    logic [DATA_W-1:0] data_a [NREQ];
    logic [MASK_W-1:0] mask_a [NREQ];

    rr_pick u_pick (
        .valid  (req_valid),
        .ptr    (rr_ptr),
        .winner (pick_winner),
        .any    (pick_any)
    );

    assign locked    = (state == ST_LOCKED);
    assign own_valid = req_valid[owner];
    assign own_last  = req_last[owner];
    assign hs        = locked && own_valid && mem_ready;

    // Release takes effect on the next edge, guaranteeing one IDLE cycle between grants.
    assign rel = (hs && own_last)
              || (hs && (beat_cnt == BCNT_W'(MAX_BURST - 1)))
              || (locked && !own_valid && (idle_cnt == ICNT_W'(IDLE_TIMEOUT - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    beat_cnt <= '0;
                    idle_cnt <= '0;
                    if (pick_any) begin
                        state <= ST_LOCKED;
                        owner <= pick_winner;
                    end
                end
                ST_LOCKED: begin
                    if (rel) begin
                        state    <= ST_IDLE;
                        rr_ptr   <= rr_next(owner);
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                    end else begin
                        if (hs)
                            beat_cnt <= beat_cnt + 1'b1;
                        if (own_valid)
                            idle_cnt <= '0;
                        else
                            idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
            data_a[i] = req_data[i*DATA_W +: DATA_W];
            mask_a[i] = req_mask[i*MASK_W +: MASK_W];
        end
    end

    always_comb begin
        req_ready = '0;
        if (locked)
            req_ready[owner] = mem_ready;
    end

    assign mem_valid = locked && own_valid;
    assign mem_addr  = addr_a[owner];
    assign mem_data  = data_a[owner];
    assign mem_mask  = mask_a[owner];
    assign mem_src   = owner;
    assign busy      = locked;

endmodule
